// File: rtl/cap_pkg.sv
// Shared definitions for the capture buffer: timestamp width and entry layout.
// Entry layout depends on the CAP_TIMESTAMP_EN macro.
package cap_pkg;

    localparam int TS_W   = 8;
    localparam int DEF_SW = 4;

`ifdef CAP_TIMESTAMP_EN
    localparam int TS_BITS = TS_W;
`else
    localparam int TS_BITS = 0;
`endif

    typedef logic [TS_W-1:0] ts_t;

`ifdef CAP_TIMESTAMP_EN
    typedef struct packed {
        ts_t               ts;
        logic [DEF_SW-1:0] sample;
    } entry_t;
`else
    typedef struct packed {
        logic [DEF_SW-1:0] sample;
    } entry_t;
`endif

endpackage

// File: rtl/cap_fifo.sv
// Circular storage for captured entries with an explicit occupancy counter.
// The caller qualifies wr_en; reads are qualified here against rd_valid.
module cap_fifo
    import cap_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int W     = 4,
    localparam int AW   = $clog2(DEPTH),
    localparam int CW   = $clog2(DEPTH) + 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          wr_en,
    input  logic [W-1:0]  wr_data,
    input  logic          rd_en,
    output logic          rd_valid,
    output logic [W-1:0]  rd_data,
    output logic [CW-1:0] count
);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          rd_fire;

    assign rd_valid = (count != '0);
    assign rd_fire  = rd_en & rd_valid;
    // Unoccupied head reads as zero so reset state is defined without clearing storage.
    assign rd_data  = rd_valid ? mem[rd_ptr] : '0;

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_en) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (rd_fire) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            count <= count + CW'(wr_en) - CW'(rd_fire);
        end
    end

endmodule

// File: rtl/q_capture_buf.sv
// Change-detecting capture buffer: stores samples that differ from the last stored one.
// Optional timestamping via the CAP_TIMESTAMP_EN macro.
module q_capture_buf
    import cap_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int SW    = 4,
    localparam int EW   = SW + TS_BITS,
    localparam int CW   = $clog2(DEPTH) + 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          cap_en,
    input  logic [SW-1:0] sample,
    input  logic          rd_ready,
    output logic          rd_valid,
    output logic [EW-1:0] rd_data,
    output logic [CW-1:0] count,
    output logic          overflow
);

    logic [SW-1:0] last_sample;
    logic          first;
    logic          cap_en_d;
    logic          eff_first;
    logic          wr_req;
    logic          rd_fire;
    logic          full;
    logic          accept;
    logic          drop;
    logic [EW-1:0] wr_data;

`ifdef CAP_TIMESTAMP_EN
    ts_t ts;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ts <= '0;
        end else begin
            ts <= ts + 1'b1;
        end
    end

    assign wr_data = {ts, sample};
`else
    assign wr_data = sample;
`endif

    // A fresh enable forces a capture even if the sample matches the stale last_sample.
    assign eff_first = first | (cap_en & ~cap_en_d);
    assign wr_req    = cap_en & (eff_first | (sample != last_sample));
    assign rd_fire   = rd_valid & rd_ready;
    assign full      = (count == CW'(DEPTH));
    assign accept    = wr_req & (~full | rd_fire);
    assign drop      = wr_req & full & ~rd_fire;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            last_sample <= '0;
            first       <= 1'b1;
            cap_en_d    <= 1'b0;
            overflow    <= 1'b0;
        end else begin
            cap_en_d <= cap_en;
            if (accept) begin
                last_sample <= sample;
                first       <= 1'b0;
            end
            if (drop) begin
                overflow <= 1'b1;
            end
        end
    end

    cap_fifo #(
        .DEPTH (DEPTH),
        .W     (EW)
    ) u_fifo (
        .clk      (clk),
        .reset    (reset),
        .wr_en    (accept),
        .wr_data  (wr_data),
        .rd_en    (rd_ready),
        .rd_valid (rd_valid),
        .rd_data  (rd_data),
        .count    (count)
    );

endmodule

// File: doc/q_capture_buf.md
Q_CAPTURE_BUF -- requirements
Module: q_capture_buf

Interface
REQ-001 SHALL have parameter DEPTH, default 8, meaning FIFO entries (power of two, 2..64).
REQ-002 SHALL have parameter SW, default 4, meaning sample width in bits.
REQ-003 SHALL have port clk  input  1  system clock; all logic on rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port cap_en  input  1  capture enable.
REQ-006 SHALL have port sample  input  SW  observed signal vector {en,d,qlatch,qff}.
REQ-007 SHALL have port rd_ready  input  1  consumer accepts the head entry.
REQ-008 SHALL have port rd_valid  output  1  head entry available.
REQ-009 SHALL have port rd_data  output  SW (+8 with CAP_TIMESTAMP_EN)  head entry.
REQ-010 SHALL have port count  output  $clog2(DEPTH)+1  current occupancy.
REQ-011 SHALL have port overflow  output  1  sticky flag: a change was dropped because the buffer was full.

Function
REQ-012 SHALL keep a last_sample register and a first flag; when cap_en=1, a write request SHALL occur if first=1 or sample!=last_sample.
REQ-013 Each accepted write SHALL store sample and update last_sample in the same edge, and SHALL clear first.
REQ-014 When cap_en=0, no write SHALL occur, and last_sample SHALL hold; a 0->1 edge of cap_en SHALL set first for that cycle's compare.
REQ-015 Write latency: an entry captured at edge N SHALL assert rd_valid after edge N (visible in cycle N+1).
REQ-016 A read SHALL occur on an edge where rd_valid=1 and rd_ready=1; rd_data SHALL advance to the next entry after that edge.
REQ-017 rd_data SHALL be stable while rd_valid=1 and rd_ready=0.
REQ-018 When full (count=DEPTH), write requests SHALL be dropped, set overflow, and leave last_sample unchanged.
REQ-019 When read and write occur together at full, the read SHALL free space first and the write SHALL be accepted; count SHALL stay DEPTH; overflow SHALL stay unchanged.
REQ-020 When read and write occur together at empty, no bypass SHALL occur; the entry SHALL appear next cycle.
REQ-021 Pointers SHALL be $clog2(DEPTH) bits and wrap modulo DEPTH; count SHALL be the explicit occupancy counter.
REQ-022 overflow SHALL clear only on reset.

Reset
REQ-023 While reset=0: count=0, rd_valid=0, rd_data=0, overflow=0, pointers=0, last_sample=0, first=1, timestamp=0; storage contents undefined.
REQ-024 Reset asserted mid-operation SHALL discard all entries immediately, asynchronously to clk.

Configuration
REQ-025 Macro CAP_TIMESTAMP_EN SHALL control timestamping.
REQ-026 With CAP_TIMESTAMP_EN defined, an 8-bit free-running counter (incremented every clk, wraps 255->0) SHALL be stored with each entry, and rd_data SHALL equal {timestamp,sample}.
REQ-027 Without CAP_TIMESTAMP_EN, the counter SHALL be absent, and rd_data SHALL be SW bits.

Structure
REQ-028 Shared package cap_pkg SHALL hold TS_W=8 and the entry typedef, with and without timestamp.
REQ-029 Storage and pointers SHALL be in sub-module cap_fifo; change detection, timestamp and overflow SHALL be in q_capture_buf.

Verification
REQ-030 The bench SHALL cover the following directed scenarios:
- reset released, cap_en=1, sample constant 4'b0101 for 10 cycles -> exactly one entry 0101; count=1.
- sample sequence 0000,0001,0001,0011,0011,0010 with rd_ready=0 -> entries 0000,0001,0011,0010 in order; count=4.
- DEPTH=8, 10 distinct changing samples, rd_ready=0 -> count=8, overflow=1; reads return the first 8 samples only.
- full buffer, rd_ready=1 and new change in the same cycle -> count stays 8; new sample becomes the tail; overflow unchanged.
- reset pulsed low mid-stream with 5 entries -> rd_valid=0 and count=0 immediately; next sample after release is captured (first=1).
- CAP_TIMESTAMP_EN defined, changes at cycles 3 and 300 after reset -> timestamps 3 and 44 (300 mod 256).
